// File: rtl/arbitro_rr_destinos.sv
// Weighted round-robin scheduler: pops one of four input FIFOs per cycle and
// forwards the returned word a cycle later to the output FIFO named by its top two bits.
// Define ARB_RR_STATS_EN to add the words_total / stall_cycles counters.
module arbitro_rr_destinos #(
  parameter int DATA_WIDTH = 6,
  parameter int WEIGHT     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  empty_P0,
  input  logic                  empty_P1,
  input  logic                  empty_P2,
  input  logic                  empty_P3,
  input  logic [DATA_WIDTH-1:0] data_in_P0,
  input  logic [DATA_WIDTH-1:0] data_in_P1,
  input  logic [DATA_WIDTH-1:0] data_in_P2,
  input  logic [DATA_WIDTH-1:0] data_in_P3,
  input  logic                  almost_full_P0,
  input  logic                  almost_full_P1,
  input  logic                  almost_full_P2,
  input  logic                  almost_full_P3,
  output logic                  pop_F0,
  output logic                  pop_F1,
  output logic                  pop_F2,
  output logic                  pop_F3,
  output logic                  push_F0,
  output logic                  push_F1,
  output logic                  push_F2,
  output logic                  push_F3,
`ifdef ARB_RR_STATS_EN
  output logic [15:0]           words_total,
  output logic [15:0]           stall_cycles,
`endif
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int              CNT_W    = $clog2(WEIGHT) + 1;
  localparam logic [CNT_W-1:0] WEIGHT_C = CNT_W'(WEIGHT);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       last_q, last_d;
  logic             vld_q, vld_d;
  logic [1:0]       sel_q, sel_d;
  logic             rst_dly_q;

  logic [3:0]       empty_v;
  logic             stall;
  logic             cont;
  logic             grant_vld;
  logic [1:0]       grant_idx;
  logic [1:0]       scan_start;
  logic [3:0]       pop_v;
  logic [3:0]       push_v;
  logic             push_en;
  logic [DATA_WIDTH-1:0] w;
  logic [1:0]       dest;

  assign empty_v = {empty_P3, empty_P2, empty_P1, empty_P0};
  assign stall   = almost_full_P0 | almost_full_P1 | almost_full_P2 | almost_full_P3;

  // First requester at or after start, wrapping mod 4; returns {found, index}.
  function automatic logic [2:0] scan_first(input logic [3:0] req, input logic [1:0] start);
    logic [2:0] r;
    logic [1:0] idx;
    r = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (req[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  assign cont = (state_q == SERVE) && !empty_v[last_q] && (cnt_q < WEIGHT_C);

  always_comb begin
    grant_vld  = 1'b0;
    grant_idx  = last_q;
    scan_start = ptr_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    state_d    = state_q;
    // A stall suspends the burst rather than ending it, so state and count are held.
    if (!reset && !rst_dly_q && !stall) begin
      if ((state_q == SERVE) && empty_v[last_q]) begin
        scan_start = last_q + 2'd1;
        ptr_d      = last_q + 2'd1;
      end
      if (cont) begin
        grant_vld = 1'b1;
        grant_idx = last_q;
      end else begin
        {grant_vld, grant_idx} = scan_first(~empty_v, scan_start);
      end
      if (grant_vld) begin
        cnt_d   = cont ? cnt_q + CNT_W'(1) : CNT_W'(1);
        last_d  = grant_idx;
        state_d = SERVE;
        if (cnt_d == WEIGHT_C) ptr_d = grant_idx + 2'd1;
      end else begin
        state_d = IDLE;
      end
    end
    vld_d = grant_vld;
    sel_d = grant_vld ? grant_idx : sel_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      cnt_q     <= '0;
      last_q    <= 2'd0;
      vld_q     <= 1'b0;
      sel_q     <= 2'd0;
      rst_dly_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      vld_q     <= vld_d;
      sel_q     <= sel_d;
      rst_dly_q <= 1'b0;
    end
  end

  assign pop_v  = grant_vld ? (4'(1) << grant_idx) : 4'd0;
  assign pop_F0 = pop_v[0];
  assign pop_F1 = pop_v[1];
  assign pop_F2 = pop_v[2];
  assign pop_F3 = pop_v[3];

  // Forwarding stage: word popped last cycle goes out now; reset drops it.
  always_comb begin
    case (sel_q)
      2'd0:    w = data_in_P0;
      2'd1:    w = data_in_P1;
      2'd2:    w = data_in_P2;
      default: w = data_in_P3;
    endcase
  end

  assign push_en  = vld_q && !reset;
  assign dest     = w[DATA_WIDTH-1 -: 2];
  assign push_v   = push_en ? (4'(1) << dest) : 4'd0;
  assign push_F0  = push_v[0];
  assign push_F1  = push_v[1];
  assign push_F2  = push_v[2];
  assign push_F3  = push_v[3];
  assign data_out = push_en ? w : '0;

`ifdef ARB_RR_STATS_EN
  logic [15:0] words_q;
  logic [15:0] stalls_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      words_q  <= 16'd0;
      stalls_q <= 16'd0;
    end else begin
      if (push_en && (words_q != 16'hFFFF)) words_q <= words_q + 16'd1;
      if (stall && !(&empty_v) && (stalls_q != 16'hFFFF)) stalls_q <= stalls_q + 16'd1;
    end
  end

  assign words_total  = words_q;
  assign stall_cycles = stalls_q;
`endif

endmodule

// File: tb/tb_arbitro_rr_destinos.sv
// Directed bench for arbitro_rr_destinos with behavioural input FIFOs
// (registered empty flag, read data valid the cycle after pop).
module tb_arbitro_rr_destinos;

  localparam int DW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic [3:0]    af_v  = 4'd0;
  logic [3:0]    empty_v;
  logic [DW-1:0] din [4] = '{default: '0};
  logic          pop_F0, pop_F1, pop_F2, pop_F3;
  logic          push_F0, push_F1, push_F2, push_F3;
  logic [DW-1:0] data_out;
  logic [3:0]    pop_v, push_v;
`ifdef ARB_RR_STATS_EN
  logic [15:0]   words_total, stall_cycles;
`endif

  logic [DW-1:0] mem [4][64];
  int            rd [4] = '{default: 0};
  int            wr [4] = '{default: 0};

  int n_vec = 0;
  int n_err = 0;

  arbitro_rr_destinos #(.DATA_WIDTH(DW), .WEIGHT(4)) dut (
    .clk(clk), .reset(reset),
    .empty_P0(empty_v[0]), .empty_P1(empty_v[1]), .empty_P2(empty_v[2]), .empty_P3(empty_v[3]),
    .data_in_P0(din[0]), .data_in_P1(din[1]), .data_in_P2(din[2]), .data_in_P3(din[3]),
    .almost_full_P0(af_v[0]), .almost_full_P1(af_v[1]),
    .almost_full_P2(af_v[2]), .almost_full_P3(af_v[3]),
    .pop_F0(pop_F0), .pop_F1(pop_F1), .pop_F2(pop_F2), .pop_F3(pop_F3),
    .push_F0(push_F0), .push_F1(push_F1), .push_F2(push_F2), .push_F3(push_F3),
`ifdef ARB_RR_STATS_EN
    .words_total(words_total), .stall_cycles(stall_cycles),
`endif
    .data_out(data_out)
  );

  assign pop_v  = {pop_F3, pop_F2, pop_F1, pop_F0};
  assign push_v = {push_F3, push_F2, push_F1, push_F0};

  assign empty_v[0] = (rd[0] == wr[0]);
  assign empty_v[1] = (rd[1] == wr[1]);
  assign empty_v[2] = (rd[2] == wr[2]);
  assign empty_v[3] = (rd[3] == wr[3]);

  always @(posedge clk) begin
    for (int p = 0; p < 4; p++) begin
      if (pop_v[p]) begin
        din[p] <= mem[p][rd[p]];
        rd[p]  <= rd[p] + 1;
      end
    end
  end

  task automatic load(input int p, input logic [DW-1:0] word);
    mem[p][wr[p]] = word;
    wr[p] = wr[p] + 1;
  endtask

  task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cyc(input string tag, input logic [3:0] epop, input logic [3:0] epush,
                         input logic [DW-1:0] edout);
    #1;
    chk_vec({tag, " pop"},  32'(pop_v),    32'(epop));
    chk_vec({tag, " push"}, 32'(push_v),   32'(epush));
    chk_vec({tag, " data"}, 32'(data_out), 32'(edout));
  endtask

  function automatic logic [3:0] oh(input logic [1:0] i);
    return 4'(1) << i;
  endfunction

  function automatic logic [DW-1:0] w1(input int p, input int i);
    return {2'((p + i) % 4), 1'(p % 2), 3'(i)};
  endfunction

  // Expected push strobe for a word in flight
  function automatic logic [3:0] ph(input logic [DW-1:0] word);
    return oh(word[DW-1 -: 2]);
  endfunction

  logic [DW-1:0] prev;
  logic          prev_v;

  initial begin
    // Reset and the cycle after it: everything quiet
    tick(); reset = 1'b1;
    for (int p = 0; p < 4; p++) for (int i = 0; i < 8; i++) load(p, w1(p, i));
    chk_cyc("rst", 4'd0, 4'd0, '0);
    tick(); reset = 1'b0;
    chk_cyc("rst+1", 4'd0, 4'd0, '0);

    // All four inputs loaded: bursts of 4, pushes one cycle behind
    prev_v = 1'b0;
    prev   = '0;
    for (int k = 0; k < 32; k++) begin
      int b, p, i;
      b = k / 4;
      p = b % 4;
      i = (b / 4) * 4 + k % 4;
      tick();
      chk_cyc("wrr", oh(2'(p)), prev_v ? ph(prev) : 4'd0, prev_v ? prev : '0);
      prev   = w1(p, i);
      prev_v = 1'b1;
    end
    tick(); chk_cyc("wrr drain", 4'd0, ph(prev), prev);
    tick(); chk_cyc("wrr idle", 4'd0, 4'd0, '0);

    // Only P2 with three dest-3 words, then ptr must sit at 3
    tick(); load(2, 6'b11_0001); load(2, 6'b11_0010); load(2, 6'b11_0011);
    chk_cyc("p2 a", 4'b0100, 4'd0, '0);
    tick(); chk_cyc("p2 b", 4'b0100, 4'b1000, 6'b11_0001);
    tick(); chk_cyc("p2 c", 4'b0100, 4'b1000, 6'b11_0010);
    tick(); chk_cyc("p2 end", 4'd0, 4'b1000, 6'b11_0011);
    tick(); load(0, 6'b01_0101); load(3, 6'b10_0110);
    chk_cyc("ptr3 P3", 4'b1000, 4'd0, '0);
    tick(); chk_cyc("ptr3 P0", 4'b0001, 4'b0100, 6'b10_0110);
    tick(); chk_cyc("ptr3 end", 4'd0, 4'b0010, 6'b01_0101);
    tick(); chk_cyc("ptr3 idle", 4'd0, 4'd0, '0);

    // P1 drains after two words, grant moves to P3 without a gap
    tick(); load(1, 6'b00_1000); load(1, 6'b11_1001);
    load(3, 6'b01_1010); load(3, 6'b10_1011); load(3, 6'b00_1100);
    chk_cyc("rot P1a", 4'b0010, 4'd0, '0);
    tick(); chk_cyc("rot P1b", 4'b0010, 4'b0001, 6'b00_1000);
    tick(); chk_cyc("rot P3a", 4'b1000, 4'b1000, 6'b11_1001);
    tick(); chk_cyc("rot P3b", 4'b1000, 4'b0010, 6'b01_1010);
    tick(); chk_cyc("rot P3c", 4'b1000, 4'b0100, 6'b10_1011);
    tick(); chk_cyc("rot end", 4'd0, 4'b0001, 6'b00_1100);
    tick(); chk_cyc("rot idle", 4'd0, 4'd0, '0);

    // Two-cycle stall mid-burst: in-flight word pushed once, count preserved
    tick(); load(0, 6'b10_0001); load(0, 6'b01_0010); load(0, 6'b00_0011); load(0, 6'b11_0100);
    load(1, 6'b01_0101); load(1, 6'b10_0110);
    chk_cyc("stl p0", 4'b0001, 4'd0, '0);
    tick(); chk_cyc("stl p1", 4'b0001, 4'b0100, 6'b10_0001);
    tick(); af_v = 4'b0010;
    chk_cyc("stl s1", 4'd0, 4'b0010, 6'b01_0010);
    tick(); chk_cyc("stl s2", 4'd0, 4'd0, '0);
    tick(); af_v = 4'd0;
    chk_cyc("stl p2", 4'b0001, 4'd0, '0);
    tick(); chk_cyc("stl p3", 4'b0001, 4'b0001, 6'b00_0011);
    tick(); chk_cyc("stl P1a", 4'b0010, 4'b1000, 6'b11_0100);
    tick(); chk_cyc("stl P1b", 4'b0010, 4'b0010, 6'b01_0101);
    tick(); chk_cyc("stl end", 4'd0, 4'b0100, 6'b10_0110);
    tick(); chk_cyc("stl idle", 4'd0, 4'd0, '0);

    // Reset the cycle after a pop: word dropped, restart at P0
    tick(); load(3, 6'b00_0111); load(3, 6'b01_1000); load(3, 6'b10_1001);
    load(0, 6'b11_1010); load(0, 6'b00_1011);
    chk_cyc("mrst pop", 4'b1000, 4'd0, '0);
    tick(); reset = 1'b1;
    chk_cyc("mrst rst", 4'd0, 4'd0, '0);
    tick(); reset = 1'b0;
    chk_cyc("mrst rst+1", 4'd0, 4'd0, '0);
    tick(); chk_cyc("mrst P0a", 4'b0001, 4'd0, '0);
    tick(); chk_cyc("mrst P0b", 4'b0001, 4'b1000, 6'b11_1010);
    tick(); chk_cyc("mrst P3a", 4'b1000, 4'b0001, 6'b00_1011);
    tick(); chk_cyc("mrst P3b", 4'b1000, 4'b0010, 6'b01_1000);
    tick(); chk_cyc("mrst end", 4'd0, 4'b0100, 6'b10_1001);
    tick(); chk_cyc("mrst idle", 4'd0, 4'd0, '0);

`ifdef ARB_RR_STATS_EN
    // 10 words through P2 with 3 stalled cycles while it holds data
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    tick(); for (int i = 0; i < 10; i++) load(2, {2'(i % 4), 4'(i)});
    af_v = 4'b0001;
    tick();
    tick();
    tick(); af_v = 4'd0;
    for (int i = 0; i < 14; i++) tick();
    chk_vec("words_total", 32'(words_total), 32'd10);
    chk_vec("stall_cycles", 32'(stall_cycles), 32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/arbitro_rr_destinos.md
# arbitro_rr_destinos

Weighted round-robin scheduler between four input FIFOs (P0–P3) and four output FIFOs (F0–F3) of the router datapath. Each cycle it chooses one non-empty input FIFO and pops it, while honouring output back-pressure. One cycle later it forwards the returned word to the output FIFO selected by the word's destination field. It owns all pop/push strobes of that stage and replaces ad-hoc per-port control.

## Interface
Parameters:
- DATA_WIDTH, 6, word width; bits [DATA_WIDTH-1:DATA_WIDTH-2] are the destination (0–3).
- WEIGHT, 4, maximum consecutive pops granted to one input before the pointer rotates; legal range 1–16.

Ports:
- clk  input  1  single clock; all state changes on posedge.
- reset  input  1  synchronous, active-high.
- empty_P0..empty_P3  input  1 each  input FIFO empty flags, registered by the FIFO; a pop in cycle N is reflected no later than cycle N+1.
- data_in_P0..data_in_P3  input  DATA_WIDTH each  input FIFO read data; valid the cycle after pop.
- almost_full_P0..almost_full_P3  input  1 each  output FIFO almost-full flags.
- pop_F0..pop_F3  output  1 each  pop strobe to input FIFO 0–3; one-hot or zero.
- push_F0..push_F3  output  1 each  push strobe to output FIFO 0–3; one-hot or zero.
- data_out  output  DATA_WIDTH  write data shared by all output FIFOs.

## Operation
- State:
  - ptr (2b): highest-priority input.
  - burst_cnt ($clog2(WEIGHT)+1 b).
  - last (2b): last granted input.
  - valid_d (1b).
  - sel_d (2b): input popped in the previous cycle.
- States: IDLE (no grant held) and SERVE (last input holding a burst). IDLE→SERVE on any pop. SERVE→IDLE when no pop occurs.
- stall = almost_full_P0|…|almost_full_P3. When stall is high, no pop is issued. An in-flight word (valid_d) is always pushed.
- Grant when not stalled:
  - In SERVE, if last is non-empty and burst_cnt < WEIGHT, grant last again.
  - Otherwise grant the first non-empty input scanning ptr, ptr+1, … mod 4.
  - At most one pop_Fx per cycle.
- On a grant to input g: burst_cnt = (g==last && SERVE) ? burst_cnt+1 : 1; last = g; valid_d←1; sel_d←g.
- When burst_cnt reaches WEIGHT, or g is found empty on a later cycle, ptr←last+1 (mod 4).
- When no input is granted (all empty or stall): valid_d←0; ptr is unchanged.
- Forwarding in cycle N+1:
  - w = data_in_P[sel_d].
  - dest = w[DATA_WIDTH-1:DATA_WIDTH-2].
  - push_F[dest] = valid_d.
  - data_out = valid_d ? w : 0.
- Output FIFOs must assert almost_full with at least 2 free entries, covering the word in flight plus the word being pushed.

## Timing
- Reset (synchronous):
  - pop_F*, push_F* = 0 in the reset cycle and the cycle after.
  - data_out = 0.
  - ptr = 0, burst_cnt = 0, valid_d = 0, state IDLE.
- Reset in mid-burst: an in-flight word is dropped (no push), and arbitration restarts at P0.
- Latency: pop in cycle N → push plus data_out in cycle N+1. Throughput is 1 word/cycle sustained.
- pop_F* are combinational from empty_P*, almost_full_P* and registered state. push_F* and data_out depend only on registered state plus data_in_P*.
- almost_full rising in cycle N suppresses the pop in cycle N. The push for the pop of cycle N-1 still occurs.
- Input emptying mid-burst: the arbiter rotates without wasting a cycle, and the grant passes to the next non-empty input in the same cycle.
- WEIGHT=1 gives pure round robin, with ptr advancing after every pop.

## Configuration
- ARB_RR_STATS_EN defined adds two outputs:
  - words_total [15:0]: increments on each push.
  - stall_cycles [15:0]: increments each cycle stall=1 while any empty_P*=0.
  - Both saturate at 16'hFFFF and reset to 0.
- ARB_RR_STATS_EN undefined: these ports and their counters do not exist. All other behaviour is identical.

## Test plan
- Reset, then P0–P3 non-empty with 8 words each, WEIGHT=4, no stall → pops P0×4, P1×4, P2×4, P3×4, P0×4…. Each push occurs 1 cycle after its pop, to the dest in the word's MSBs.
- Only P2 non-empty with 3 words, dest=3 → pop_F2 for 3 consecutive cycles, then push_F3 for 3 cycles with matching data. Afterwards IDLE, and the next grant scans from ptr=3.
- Sustained traffic, almost_full_P1=1 for 2 cycles → no pops in those cycles. The in-flight word is still pushed once, and the burst resumes with the burst count preserved.
- P1 has 2 words with WEIGHT=4, P3 non-empty → P1,P1 then P3 with no idle cycle.
- reset asserted the cycle after a pop → no push that cycle, all outputs 0, and the next grant goes to P0.
- With ARB_RR_STATS_EN: 10 words forwarded and 3 stall cycles → words_total=10, stall_cycles=3.
